// File: rtl/i2c_slave_pkg.sv
// Shared constants for the I2C register bank: register map, FSM encoding, requester IDs.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_slave_pkg;

    // Register map
    localparam int ADDR_PENDING = 0;
    localparam int ADDR_ENABLE  = 1;
    localparam int ADDR_GP_BASE = 2;
    localparam int ADDR_LOCK    = 15;

    // Number of PENDING bits; these track writes to ADDR_GP_BASE .. ADDR_GP_BASE+PEND_BITS-1
    localparam int PEND_BITS    = 8;

    // Requester IDs, also used as the round-robin history value
    localparam logic REQ_I2C  = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/i2c_rr_arb2.sv
// Two-way round-robin picker; on a tie the side that did not win last time wins.
// Latency: combinational pick; history updates on the clock edge where i_upd is high.
// Backpressure: none; requesters hold their request until granted by the enclosing FSM.
module i2c_rr_arb2
    import i2c_slave_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_i2c,
    input  logic i_req_host,
    input  logic i_upd,
    input  logic i_upd_id,
    output logic o_any,
    output logic o_win
);

    logic r_rr_last;

    // Round-robin history; reset to HOST so the I2C side takes the first tie
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_last <= REQ_HOST;
        end else if (i_upd) begin
            r_rr_last <= i_upd_id;
        end
    end

    // Winner select: a lone requester wins, a tie goes to the side opposite the last winner
    always_comb begin
        o_any = i_req_i2c | i_req_host;
        o_win = REQ_HOST;
        if (i_req_i2c && i_req_host) begin
            o_win = (r_rr_last == REQ_HOST) ? REQ_I2C : REQ_HOST;
        end else if (i_req_i2c) begin
            o_win = REQ_I2C;
        end
    end

endmodule

// File: rtl/i2c_regbank_arbiter.sv
// 8-bit register bank shared by the I2C slave side and host logic, with pending-write interrupt.
// Latency: req -> gnt 2 cycles, req -> rvalid 3 cycles; one access per 3 cycles at most.
// Backpressure: requester holds req until its gnt pulse; the loser of arbitration simply waits.
// Optional: I2C_REG_WRITE_PROTECT_EN adds a host-only LOCK register at addr 15 blocking I2C writes.
module i2c_regbank_arbiter
    import i2c_slave_pkg::*;
#(
    parameter int             ADDR_W       = 4,
    parameter int             DATA_W       = 8,
    parameter logic [7:0]     INT_MASK_RST = 8'hFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_i2c_req,
    input  logic              i_i2c_we,
    input  logic [ADDR_W-1:0] i_i2c_addr,
    input  logic [DATA_W-1:0] i_i2c_wdata,
    output logic              o_i2c_gnt,
    output logic              o_i2c_rvalid,
    output logic [DATA_W-1:0] o_i2c_rdata,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_gnt,
    output logic              o_host_rvalid,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic              o_int
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_win;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_bank [DEPTH];
    logic [DATA_W-1:0]   r_rd_cap;
    logic                r_i2c_gnt;
    logic                r_host_gnt;
    logic                r_i2c_rvalid;
    logic                r_host_rvalid;
    logic [DATA_W-1:0]   r_i2c_rdata;
    logic [DATA_W-1:0]   r_host_rdata;
    logic                r_int;

    logic                w_any;
    logic                w_win;
    logic                w_latch;
    logic                w_access;
    logic                w_resp;
    logic                w_is_i2c;
    logic                w_protect;
    logic                w_bank_we;
    logic [2:0]          w_pidx;
    logic [DATA_W-1:0]   w_pend_set;
    logic [DATA_W-1:0]   w_pend_clr;

    i2c_rr_arb2 u_arb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req_i2c  (i_i2c_req),
        .i_req_host (i_host_req),
        .i_upd      (w_access),
        .i_upd_id   (r_win),
        .o_any      (w_any),
        .o_win      (w_win)
    );

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and per-state strobes
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_access    = 1'b0;
        w_resp      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_access    = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_resp      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the winning request so the requester may drop req after its gnt
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_win   <= REQ_HOST;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_latch) begin
            r_win   <= w_win;
            r_we    <= (w_win == REQ_I2C) ? i_i2c_we    : i_host_we;
            r_addr  <= (w_win == REQ_I2C) ? i_i2c_addr  : i_host_addr;
            r_wdata <= (w_win == REQ_I2C) ? i_i2c_wdata : i_host_wdata;
        end
    end

    // Write decode: ordinary register write, PENDING set from I2C, PENDING W1C from host
    always_comb begin
        w_is_i2c   = (r_win == REQ_I2C);
`ifdef I2C_REG_WRITE_PROTECT_EN
        // LOCK is never I2C-writable; LOCK[0] discards every I2C write above ENABLE
        w_protect  = w_is_i2c &&
                     ((r_addr == ADDR_W'(ADDR_LOCK)) ||
                      (r_bank[ADDR_LOCK][0] && (r_addr >= ADDR_W'(ADDR_GP_BASE))));
`else
        w_protect  = 1'b0;
`endif
        w_bank_we  = w_access && r_we && !w_protect && (r_addr != ADDR_W'(ADDR_PENDING));
        w_pidx     = 3'(r_addr - ADDR_W'(ADDR_GP_BASE));
        w_pend_set = '0;
        w_pend_clr = '0;
        if (w_access && r_we && w_is_i2c && !w_protect &&
            (r_addr >= ADDR_W'(ADDR_GP_BASE)) &&
            (r_addr <  ADDR_W'(ADDR_GP_BASE + PEND_BITS))) begin
            w_pend_set[w_pidx] = 1'b1;
        end
        if (w_access && r_we && !w_is_i2c && (r_addr == ADDR_W'(ADDR_PENDING))) begin
            w_pend_clr = r_wdata;
        end
    end

    // Register bank; PENDING is only touched by the set/clear terms, never by a plain write
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bank[i] <= '0;
            end
            r_bank[ADDR_ENABLE] <= INT_MASK_RST;
        end else begin
            if (w_bank_we) begin
                r_bank[r_addr] <= r_wdata;
            end
            r_bank[ADDR_PENDING] <= (r_bank[ADDR_PENDING] & ~w_pend_clr) | w_pend_set;
        end
    end

    // Registered grant/response outputs, read capture and interrupt level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_cap      <= '0;
            r_i2c_gnt     <= 1'b0;
            r_host_gnt    <= 1'b0;
            r_i2c_rvalid  <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_i2c_rdata   <= '0;
            r_host_rdata  <= '0;
            r_int         <= 1'b0;
        end else begin
            if (w_access) begin
                r_rd_cap <= r_bank[r_addr];
            end
            r_i2c_gnt     <= w_access &&  w_is_i2c;
            r_host_gnt    <= w_access && !w_is_i2c;
            r_i2c_rvalid  <= w_resp   &&  w_is_i2c;
            r_host_rvalid <= w_resp   && !w_is_i2c;
            if (w_resp && !r_we &&  w_is_i2c) r_i2c_rdata  <= r_rd_cap;
            if (w_resp && !r_we && !w_is_i2c) r_host_rdata <= r_rd_cap;
            r_int <= |(r_bank[ADDR_PENDING] & r_bank[ADDR_ENABLE]);
        end
    end

    assign o_i2c_gnt     = r_i2c_gnt;
    assign o_host_gnt    = r_host_gnt;
    assign o_i2c_rvalid  = r_i2c_rvalid;
    assign o_host_rvalid = r_host_rvalid;
    assign o_i2c_rdata   = r_i2c_rdata;
    assign o_host_rdata  = r_host_rdata;
    assign o_int         = r_int;

endmodule

// File: tb/tb_i2c_regbank_arbiter.sv
// Self-checking bench for i2c_regbank_arbiter: reference register model plus per-side
// response queues; a monitor pops an expected entry on every rvalid.
module tb_i2c_regbank_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i2c_req = 1'b0, i2c_we = 1'b0;
    logic [3:0] i2c_addr = '0;
    logic [7:0] i2c_wdata = '0;
    logic       i2c_gnt, i2c_rvalid;
    logic [7:0] i2c_rdata;
    logic       host_req = 1'b0, host_we = 1'b0;
    logic [3:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic       int_o;

    int checks = 0;
    int errors = 0;

    // {is_read, expected rdata}
    logic [8:0] q_i2c[$];
    logic [8:0] q_host[$];
    bit         gnt_log[$];
    logic [7:0] m_bank [16];
    bit         prev_i2c_gnt = 0, prev_host_gnt = 0;

    i2c_regbank_arbiter dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_i2c_req    (i2c_req),
        .i_i2c_we     (i2c_we),
        .i_i2c_addr   (i2c_addr),
        .i_i2c_wdata  (i2c_wdata),
        .o_i2c_gnt    (i2c_gnt),
        .o_i2c_rvalid (i2c_rvalid),
        .o_i2c_rdata  (i2c_rdata),
        .i_host_req   (host_req),
        .i_host_we    (host_we),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata),
        .o_host_gnt   (host_gnt),
        .o_host_rvalid(host_rvalid),
        .o_host_rdata (host_rdata),
        .o_int        (int_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Response monitor: grant exclusivity, rvalid one cycle after gnt, scoreboard pop
    always @(negedge clk) begin
        logic [8:0] e;
        if (i2c_gnt || host_gnt) begin
            checks++;
            if (i2c_gnt && host_gnt) begin
                errors++;
                $display("FAIL double_gnt: i2c_gnt=%b host_gnt=%b required one-hot", i2c_gnt, host_gnt);
            end
            gnt_log.push_back(host_gnt);
        end
        if (i2c_rvalid) begin
            checks++;
            if (!prev_i2c_gnt) begin
                errors++;
                $display("FAIL i2c_rvalid_timing: prev gnt=%b required 1", prev_i2c_gnt);
            end
            if (q_i2c.size() == 0) begin
                errors++;
                $display("FAIL i2c_unexpected_rvalid: rvalid=1 required no response");
            end else begin
                e = q_i2c.pop_front();
                if (e[8]) begin
                    checks++;
                    if (i2c_rdata !== e[7:0]) begin
                        errors++;
                        $display("FAIL i2c_rdata: got %h required %h", i2c_rdata, e[7:0]);
                    end
                end
            end
        end
        if (host_rvalid) begin
            checks++;
            if (!prev_host_gnt) begin
                errors++;
                $display("FAIL host_rvalid_timing: prev gnt=%b required 1", prev_host_gnt);
            end
            if (q_host.size() == 0) begin
                errors++;
                $display("FAIL host_unexpected_rvalid: rvalid=1 required no response");
            end else begin
                e = q_host.pop_front();
                if (e[8]) begin
                    checks++;
                    if (host_rdata !== e[7:0]) begin
                        errors++;
                        $display("FAIL host_rdata: got %h required %h", host_rdata, e[7:0]);
                    end
                end
            end
        end
        prev_i2c_gnt  = i2c_gnt;
        prev_host_gnt = host_gnt;
    end

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_bank[i] = 8'h00;
        m_bank[1] = 8'hFF;
    endfunction

    function automatic void model_write(input bit side, input logic [3:0] addr, input logic [7:0] d);
        bit prot;
        if (side) begin
            if (addr == 4'd0) m_bank[0] = m_bank[0] & ~d;
            else              m_bank[addr] = d;
        end else begin
            prot = 1'b0;
`ifdef I2C_REG_WRITE_PROTECT_EN
            prot = (addr == 4'd15) || (m_bank[15][0] && addr >= 4'd2);
`endif
            if (addr != 4'd0 && !prot) begin
                m_bank[addr] = d;
                if (addr >= 4'd2 && addr < 4'd10) m_bank[0][addr - 4'd2] = 1'b1;
            end
        end
    endfunction

    function automatic logic exp_int();
        return |(m_bank[0] & m_bank[1]);
    endfunction

    // One access from one side; reports gnt latency and whether rvalid followed gnt
    task automatic access(input bit side, input bit we, input logic [3:0] addr,
                          input logic [7:0] wdata, output int gnt_lat, output bit rv_next);
        logic [8:0] e;
        e = {~we, m_bank[addr]};
        if (side) q_host.push_back(e); else q_i2c.push_back(e);
        if (we) model_write(side, addr, wdata);
        if (side) begin
            host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
        end else begin
            i2c_req = 1'b1; i2c_we = we; i2c_addr = addr; i2c_wdata = wdata;
        end
        gnt_lat = -1;
        rv_next = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #2;
            if ((side && host_gnt) || (!side && i2c_gnt)) begin
                gnt_lat = c;
                break;
            end
        end
        if (side) host_req = 1'b0; else i2c_req = 1'b0;
        if (gnt_lat < 0) begin
            checks++; errors++;
            $display("FAIL gnt_timeout: side=%0d no gnt required gnt within 20 cycles", side);
            q_i2c.delete(); q_host.delete();
        end else begin
            @(posedge clk); #2;
            rv_next = side ? host_rvalid : i2c_rvalid;
            for (int c = 0; c < 5 && (q_i2c.size() + q_host.size()) != 0; c++) begin
                @(posedge clk); #2;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i2c_req = 1'b0; host_req = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int lat; bit rv;
        do_reset();
        checks++;
        if ({i2c_gnt, i2c_rvalid, host_gnt, host_rvalid, int_o} !== 5'b0 ||
            i2c_rdata !== 8'h00 || host_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: gnt/rv/int=%b%b%b%b%b rdata=%h/%h required all 0",
                     i2c_gnt, i2c_rvalid, host_gnt, host_rvalid, int_o, i2c_rdata, host_rdata);
        end
        access(1'b1, 1'b0, 4'd1, 8'h00, lat, rv);
        checks++;
        if (lat != 2) begin errors++; $display("FAIL host_gnt_latency: got %0d required 2", lat); end
        checks++;
        if (rv !== 1'b1) begin errors++; $display("FAIL host_rvalid_latency: rvalid=%b required 1 at +3", rv); end
        checks++;
        if (int_o !== 1'b0) begin errors++; $display("FAIL reset_int: got %b required 0", int_o); end
    endtask

    task automatic test_i2c_write();
        int lat; bit rv;
        access(1'b0, 1'b1, 4'd3, 8'hA5, lat, rv);
        checks++;
        if (lat != 2 || rv !== 1'b1) begin
            errors++;
            $display("FAIL i2c_write_timing: gnt_lat=%0d rv=%b required 2/1", lat, rv);
        end
        checks++;
        if (int_o !== exp_int()) begin errors++; $display("FAIL i2c_write_int: got %b required %b", int_o, exp_int()); end
        access(1'b1, 1'b0, 4'd0, 8'h00, lat, rv);
        access(1'b1, 1'b0, 4'd3, 8'h00, lat, rv);
    endtask

    task automatic test_round_robin();
        int n;
        gnt_log.delete();
        q_i2c.push_back({1'b1, m_bank[3]});
        q_i2c.push_back({1'b1, m_bank[3]});
        q_host.push_back({1'b1, m_bank[1]});
        i2c_req = 1'b1;  i2c_we = 1'b0;  i2c_addr = 4'd3;
        host_req = 1'b1; host_we = 1'b0; host_addr = 4'd1;
        n = 0;
        while (gnt_log.size() < 3 && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        i2c_req = 1'b0; host_req = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        checks++;
        if (gnt_log.size() != 3) begin
            errors++;
            $display("FAIL rr_gnt_count: got %0d required 3", gnt_log.size());
        end else begin
            checks++;
            if (gnt_log[0] != 1'b0 || gnt_log[1] != 1'b1 || gnt_log[2] != 1'b0) begin
                errors++;
                $display("FAIL rr_order: got %0d%0d%0d required 010 (I2C,HOST,I2C)",
                         gnt_log[0], gnt_log[1], gnt_log[2]);
            end
        end
        checks++;
        if (q_i2c.size() + q_host.size() != 0) begin
            errors++;
            $display("FAIL rr_responses: %0d outstanding required 0", q_i2c.size() + q_host.size());
        end
        q_i2c.delete(); q_host.delete();
    endtask

    task automatic test_pending();
        int lat; bit rv;
        access(1'b1, 1'b1, 4'd0, 8'h02, lat, rv);
        checks++;
        if (int_o !== 1'b0) begin errors++; $display("FAIL w1c_int: got %b required 0", int_o); end
        access(1'b1, 1'b0, 4'd0, 8'h00, lat, rv);
        access(1'b1, 1'b1, 4'd1, 8'h00, lat, rv);
        access(1'b0, 1'b1, 4'd2, 8'h11, lat, rv);
        checks++;
        if (int_o !== 1'b0) begin errors++; $display("FAIL masked_int: got %b required 0", int_o); end
        access(1'b0, 1'b1, 4'd10, 8'h77, lat, rv);
        access(1'b0, 1'b1, 4'd0, 8'hFF, lat, rv);
        access(1'b0, 1'b0, 4'd0, 8'h00, lat, rv);
        access(1'b1, 1'b0, 4'd10, 8'h00, lat, rv);
        access(1'b1, 1'b1, 4'd1, 8'h01, lat, rv);
        checks++;
        if (int_o !== 1'b1) begin errors++; $display("FAIL unmask_int: got %b required 1", int_o); end
        access(1'b1, 1'b1, 4'd1, 8'h00, lat, rv);
    endtask

    task automatic test_reset_mid_access();
        int lat; bit rv;
        i2c_req = 1'b1; i2c_we = 1'b1; i2c_addr = 4'd4; i2c_wdata = 8'h77;
        @(posedge clk); #2;
        rst = 1'b1; i2c_req = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        model_reset();
        checks++;
        if ({i2c_gnt, i2c_rvalid, host_gnt, host_rvalid, int_o} !== 5'b0 ||
            i2c_rdata !== 8'h00 || host_rdata !== 8'h00) begin
            errors++;
            $display("FAIL midreset_outputs: gnt/rv/int=%b%b%b%b%b rdata=%h/%h required all 0",
                     i2c_gnt, i2c_rvalid, host_gnt, host_rvalid, int_o, i2c_rdata, host_rdata);
        end
        repeat (5) @(posedge clk);
        #2;
        access(1'b1, 1'b0, 4'd4, 8'h00, lat, rv);
        access(1'b1, 1'b0, 4'd1, 8'h00, lat, rv);
    endtask

`ifdef I2C_REG_WRITE_PROTECT_EN
    task automatic test_write_protect();
        int lat; bit rv;
        access(1'b1, 1'b1, 4'd15, 8'h01, lat, rv);
        access(1'b0, 1'b1, 4'd5, 8'h3C, lat, rv);
        checks++;
        if (lat != 2 || rv !== 1'b1) begin
            errors++;
            $display("FAIL locked_write_timing: gnt_lat=%0d rv=%b required 2/1", lat, rv);
        end
        access(1'b0, 1'b1, 4'd15, 8'h00, lat, rv);
        access(1'b1, 1'b0, 4'd5, 8'h00, lat, rv);
        access(1'b1, 1'b0, 4'd0, 8'h00, lat, rv);
        access(1'b1, 1'b0, 4'd15, 8'h00, lat, rv);
        access(1'b1, 1'b1, 4'd15, 8'h00, lat, rv);
        access(1'b0, 1'b1, 4'd5, 8'h3C, lat, rv);
        access(1'b1, 1'b0, 4'd5, 8'h00, lat, rv);
        access(1'b1, 1'b0, 4'd0, 8'h00, lat, rv);
    endtask
`else
    task automatic test_addr15_plain();
        int lat; bit rv;
        access(1'b0, 1'b1, 4'd15, 8'h5A, lat, rv);
        access(1'b1, 1'b0, 4'd15, 8'h00, lat, rv);
        access(1'b0, 1'b1, 4'd5, 8'h3C, lat, rv);
        access(1'b1, 1'b0, 4'd5, 8'h00, lat, rv);
        access(1'b1, 1'b0, 4'd0, 8'h00, lat, rv);
    endtask
`endif

    initial begin
        test_reset();
        test_i2c_write();
        test_round_robin();
        test_pending();
        test_reset_mid_access();
`ifdef I2C_REG_WRITE_PROTECT_EN
        test_write_protect();
`else
        test_addr15_plain();
`endif
        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
